// File: rtl/out_drain_if.sv
// out_drain_if: drain-job control, core vector input and beat output of out_drain.
interface out_drain_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int out_bw  = 32
);
  logic                   start;
  logic [10:0]            expect_cnt;
  logic                   relu_en;
  logic                   in_valid;
  logic [psum_bw*col-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [out_bw-1:0]      out_data;
  logic                   out_ready;
  logic                   out_last;
  logic                   done;
  logic                   overflow;
  modport master (
    output start, expect_cnt, relu_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, done, overflow
  );
  modport slave (
    input  start, expect_cnt, relu_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, done, overflow
  );
endinterface

// File: rtl/out_drain.sv
// out_drain: buffers core output vectors (optional ReLU) and streams them as out_bw beats.
module out_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int out_bw  = 32,
  parameter int depth   = 4
) (
  input logic      clk,
  input logic      reset,
  out_drain_if.slave bus
);
  localparam int vw = psum_bw * col;
  localparam int nb = vw / out_bw;
  localparam int aw = $clog2(depth);
  localparam int bw = nb > 1 ? $clog2(nb) : 1;
  typedef enum logic [1:0] {s_idle, s_run, s_done} state_t;
  state_t        state, state_d;
  logic [vw-1:0] mem [depth];
  logic [aw:0]   wr_ptr, rd_ptr;
  logic [bw-1:0] beat;
  logic [10:0]   accepted, emitted, expect_q;
  logic          relu_q, ovf_q, full, empty, arm, push, drop, xfer, pop, final_beat;
  logic [vw-1:0] wdata, head;
  assign full            = (wr_ptr ^ rd_ptr) == {1'b1, {aw{1'b0}}};
  assign empty           = wr_ptr == rd_ptr;
  assign arm             = bus.start && state != s_run;
  assign bus.in_ready    = state == s_run && !full && accepted < expect_q;
  assign push            = bus.in_valid && bus.in_ready;
  assign drop            = bus.in_valid && !bus.in_ready && state == s_run;
  assign head            = mem[rd_ptr[aw-1:0]];
  assign final_beat      = beat == bw'(nb - 1);
  assign bus.out_valid   = !empty;
  assign bus.out_data    = empty ? '0 : head[out_bw*beat +: out_bw];
  assign bus.out_last    = !empty && final_beat && emitted + 11'd1 == expect_q;
  assign bus.done        = state == s_done;
  assign bus.overflow    = ovf_q;
  assign xfer            = bus.out_valid && bus.out_ready;
  assign pop             = xfer && final_beat;
  always_comb begin
    wdata = bus.in_data;
    for (int k = 0; k < col; k++)
      if (relu_q && bus.in_data[psum_bw*(k+1)-1]) wdata[psum_bw*k +: psum_bw] = '0;
  end
  always_comb begin
    state_d = state;
    state_d = arm ? (bus.expect_cnt == '0 ? s_done : s_run)
            : (state == s_run && xfer && bus.out_last) ? s_done : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= s_idle;
    else state <= state_d;
  // Storage is not reset; out_data is gated by empty so stale contents never leak.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[aw-1:0]] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat     <= '0;
      accepted <= '0;
      emitted  <= '0;
      expect_q <= '0;
      relu_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (arm) begin
        accepted <= '0;
        emitted  <= '0;
        expect_q <= bus.expect_cnt;
        relu_q   <= bus.relu_en;
        ovf_q    <= 1'b0;
      end else begin
        if (push) accepted <= accepted + 11'd1;
        if (pop) emitted <= emitted + 11'd1;
        if (drop) ovf_q <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (xfer) beat <= final_beat ? '0 : beat + 1'b1;
    end
endmodule

// File: tb/tb_out_drain.sv
// tb_out_drain: directed and randomized jobs checked against a beat-queue reference model.
module tb_out_drain;
  localparam int COL = 8, PW = 16, OW = 32, DEPTH = 4;
  localparam int VW = COL * PW, NB = VW / OW;
  logic clk, reset;
  int tests = 0, fails = 0;
  out_drain_if #(.col(COL), .psum_bw(PW), .out_bw(OW)) bus();
  out_drain #(.col(COL), .psum_bw(PW), .out_bw(OW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] q[$], got[$];
  int acc, exp_m, beats_out;
  bit running, done_m, ovf_m, relu_m;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v, input bit en);
    logic [VW-1:0] r;
    r = v;
    for (int k = 0; k < COL; k++)
      if (en && $signed(v[PW*k +: PW]) < 0) r[PW*k +: PW] = '0;
    return r;
  endfunction
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [VW-1:0] ramp_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < COL; k++) v[PW*k +: PW] = PW'(k + 1);
    return v;
  endfunction
  // One clock: check outputs against the model, advance the model, then cross the edge.
  task automatic tick();
    int pend;
    bit rdy;
    logic [VW-1:0] v;
    pend = q.size();
    rdy = running && (pend + NB - 1) / NB < DEPTH && acc < exp_m;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, pend > 0);
    if (pend > 0) begin
      chk("out_data", bus.out_data, q[0]);
      chk("out_last", bus.out_last, beats_out == exp_m * NB - 1);
    end
    chk("done", bus.done, done_m);
    chk("overflow", bus.overflow, ovf_m);
    if (bus.start && !running) begin
      exp_m = int'(bus.expect_cnt);
      relu_m = bus.relu_en;
      acc = 0;
      beats_out = 0;
      ovf_m = 0;
      running = exp_m != 0;
      done_m = exp_m == 0;
    end else if (running && bus.in_valid) begin
      if (rdy) begin
        v = relu_vec(bus.in_data, relu_m);
        for (int b = 0; b < NB; b++) q.push_back(v[OW*b +: OW]);
        acc++;
      end else ovf_m = 1;
    end
    if (pend > 0 && bus.out_ready) begin
      got.push_back(q.pop_front());
      beats_out++;
      if (beats_out == exp_m * NB) begin
        running = 0;
        done_m = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input int cnt, input bit relu);
    bus.start = 1'b1;
    bus.expect_cnt = 11'(cnt);
    bus.relu_en = relu;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
  endtask
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #2;
    check_zero(tag);
    q.delete();
    running = 0; done_m = 0; ovf_m = 0; acc = 0; beats_out = 0; exp_m = 0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] e1 [4];
    logic [VW-1:0] v;
    int cnt;
    e1 = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
    reset = 1'b0;
    bus.start = 0; bus.expect_cnt = 0; bus.relu_en = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    running = 0; done_m = 0; ovf_m = 0; acc = 0; beats_out = 0; exp_m = 0;
    #3;
    check_zero("por");
    #4;
    reset = 1'b1;
    @(posedge clk);
    #1;
    // single vector, no ReLU, known beat values
    got.delete();
    bus.out_ready = 1;
    start_job(1, 0);
    bus.in_valid = 1; bus.in_data = ramp_vec();
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("s1_nbeats", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("s1_beat", i < got.size() ? got[i] : 32'hx, e1[i]);
    chk("s1_done", bus.done, 1);
    // ReLU clamps a negative lane 0, restart from DONE
    got.delete();
    start_job(1, 1);
    v = ramp_vec();
    v[PW-1:0] = 16'hFFFF;
    bus.in_valid = 1; bus.in_data = v;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("s2_beat0", got.size() > 0 ? got[0] : 32'hx, 32'h00020000);
    chk("s2_done", bus.done, 1);
    // empty job
    start_job(0, 0);
    chk("s6_done", bus.done, 1);
    bus.in_valid = 1; bus.in_data = rand_vec();
    for (int i = 0; i < 3; i++) tick();
    bus.in_valid = 0;
    chk("s6_ovf", bus.overflow, 0);
    // three vectors, output stalled every other cycle
    got.delete();
    start_job(3, 0);
    for (int i = 0; i < 60 && !done_m; i++) begin
      bus.in_valid = i == 0 || i == 2 || i == 4;
      bus.in_data = rand_vec();
      bus.out_ready = i % 2;
      tick();
    end
    bus.in_valid = 0;
    chk("s4_nbeats", got.size(), 12);
    chk("s4_done", bus.done, 1);
    // overflow with blocked output
    got.delete();
    bus.out_ready = 0;
    start_job(6, 0);
    bus.in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = rand_vec();
      tick();
    end
    bus.in_valid = 0;
    chk("s3_ovf", bus.overflow, 1);
    bus.out_ready = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("s3_nbeats", got.size(), 16);
    chk("s3_done", bus.done, 0);
    reset_pulse("s3_rst");
    // reset mid-job discards buffered data
    got.delete();
    start_job(2, 0);
    bus.in_valid = 1;
    bus.in_data = rand_vec();
    tick();
    bus.in_data = rand_vec();
    tick();
    bus.in_valid = 0;
    tick();
    chk("s5_nbeats", got.size(), 2);
    reset_pulse("s5_rst");
    bus.in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = rand_vec();
      tick();
    end
    bus.in_valid = 0;
    chk("s5_after", got.size(), 2);
    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      got.delete();
      cnt = $urandom_range(4, 10);
      start_job(cnt, $urandom % 2);
      for (int i = 0; i < 800 && !done_m; i++) begin
        bus.in_valid = $urandom % 2;
        bus.in_data = rand_vec();
        bus.out_ready = $urandom % 4 != 0;
        tick();
      end
      bus.in_valid = 0;
      chk("rand_nbeats", got.size(), cnt * NB);
      chk("rand_done", bus.done, 1);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/out_drain.md
OUT_DRAIN -- requirements
Module: out_drain

Interface
REQ-001 Parameter col, default 8: number of output lanes per vector.
REQ-002 Parameter psum_bw, default 16: signed width of one lane.
REQ-003 Parameter out_bw, default 32: width of one output beat; psum_bw*col SHALL be an integer multiple of out_bw, giving NB = psum_bw*col/out_bw beats per vector (default NB = 4).
REQ-004 Parameter depth, default 4: vector FIFO depth; SHALL be a power of two and at least 2.
REQ-005 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse that arms a drain job.
REQ-008 expect_cnt  in  11  number of vectors in the job; sampled on start.
REQ-009 relu_en  in  1  ReLU enable; sampled on start.
REQ-010 in_valid  in  1  core output vector is present this cycle; the core applies no backpressure.
REQ-011 in_data  in  psum_bw*col  core output vector; lane k occupies bits [psum_bw*(k+1)-1 : psum_bw*k].
REQ-012 in_ready  out  1  the FIFO will accept in_data this cycle.
REQ-013 out_valid  out  1  a beat is available on out_data.
REQ-014 out_data  out  out_bw  current beat.
REQ-015 out_ready  in  1  downstream accepts the beat.
REQ-016 out_last  out  1  qualifies the final beat of the final vector of the job.
REQ-017 done  out  1  level; the job is complete.
REQ-018 overflow  out  1  sticky; an input vector was dropped.

Function
REQ-019 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-020 start in IDLE or DONE SHALL latch expect_cnt and relu_en, clear the accepted and emitted counters, and clear overflow; it SHALL then go to RUN, or to DONE on the next edge if expect_cnt = 0.
REQ-021 start while in RUN SHALL be ignored.
REQ-022 in_ready SHALL be combinational and equal (state==RUN) && !fifo_full && (accepted < expect).
REQ-023 A push SHALL occur when in_valid && in_ready; accepted SHALL then increment.
REQ-024 When relu_en is latched, each signed lane SHALL be written to the FIFO as 0 if negative and unchanged otherwise; ReLU SHALL be applied on push.
REQ-025 in_valid && !in_ready in RUN SHALL drop the vector and set overflow; in_valid in IDLE or DONE SHALL be ignored without setting overflow.
REQ-026 A push into a full FIFO SHALL NOT occur, even if a pop happens in the same cycle.
REQ-027 out_valid SHALL equal fifo_not_empty; out_data SHALL be beat b of the head vector, i.e. bits [out_bw*(b+1)-1 : out_bw*b], with beat 0 sent first.
REQ-028 A beat transfer SHALL occur on out_valid && out_ready, and b SHALL then increment.
REQ-029 On the transfer of beat NB-1, b SHALL wrap to 0, the head SHALL pop, and emitted SHALL increment.
REQ-030 out_data and out_last SHALL be held stable while out_valid && !out_ready.
REQ-031 Latency: a vector pushed on edge N SHALL present beat 0 with out_valid=1 after edge N, with no bubble.
REQ-032 A full-throughput job SHALL sustain one beat per cycle.
REQ-033 Simultaneous push and pop SHALL be supported when the FIFO is not full, leaving the occupancy unchanged.
REQ-034 out_last SHALL be 1 only while beat NB-1 is presented and emitted = expect-1.
REQ-035 The final transfer of a job SHALL move the FSM from RUN to DONE.
REQ-036 done SHALL be 1 in DONE and 0 otherwise.
REQ-037 FIFO read and write pointers SHALL wrap modulo depth, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-038 A new start in DONE SHALL restart cleanly; the FIFO is empty at that point by construction.

Reset
REQ-039 reset=0 SHALL immediately force the following values, regardless of clk: state IDLE, FIFO empty, pointers 0, b 0, counters 0, latched expect 0, latched relu_en 0, in_ready 0, out_valid 0, out_data 0, out_last 0, done 0, overflow 0.
REQ-040 Reset asserted mid-job SHALL discard all buffered data; after release, no beat SHALL appear until a new start and a push.

Verification
REQ-041 Scenario: start with expect_cnt=1, relu_en=0, one push of lanes 0..7 = 1..8, out_ready=1 -> beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 on consecutive cycles, out_last on the 4th beat, done=1 on the next cycle.
REQ-042 Scenario: same push with relu_en=1 and lane 0 = 0xFFFF -> first beat = 0x00020000.
REQ-043 Scenario: expect_cnt=6, out_ready=0, in_valid held for 6 cycles -> 4 pushes accepted, 2 dropped, overflow=1, in_ready=0 from the 5th cycle; after out_ready=1, 16 beats are sent and done stays 0.
REQ-044 Scenario: expect_cnt=3, pushes 1 cycle apart, out_ready toggling 1/0 -> 12 beats in order, data stable while stalled, out_last only on the 12th beat, then done.
REQ-045 Scenario: reset pulsed low after 2 beats of a 2-vector job -> all outputs 0 immediately; after release, 0 beats until a new start.
REQ-046 Scenario: start with expect_cnt=0 -> done=1 one cycle later, in_ready stays 0, overflow stays 0.
